// File: rtl/fighter_pkg.sv
// Shared types for the per-player fighter controller: state encoding seen by the
// renderer and hit arbiter, decoded action bit positions, and counter width.
package fighter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WALK   = 3'd1,
        CROUCH = 3'd2,
        AIR_UP = 3'd3,
        AIR_DN = 3'd4,
        ATTACK = 3'd5,
        STUN   = 3'd6,
        KO     = 3'd7
    } fstate_t;

    // act = {up, down, left, right, punch, kick}
    localparam int ACT_KICK  = 0;
    localparam int ACT_PUNCH = 1;
    localparam int ACT_RIGHT = 2;
    localparam int ACT_LEFT  = 3;
    localparam int ACT_DOWN  = 4;
    localparam int ACT_UP    = 5;
    localparam int ACT_W     = 6;

    localparam int CNT_W = 8;

endpackage

// File: rtl/fighter_overlap.sv
// Combinational box test: do boxes A and B overlap, and is B on the side A faces
// (dir = 0 faces +x, dir = 1 faces -x).
module fighter_overlap #(
    parameter int POS_W = 10
) (
    input  logic [POS_W-1:0] a_x,
    input  logic [POS_W-1:0] a_y,
    input  logic [POS_W-1:0] a_w,
    input  logic [POS_W-1:0] a_h,
    input  logic [POS_W-1:0] b_x,
    input  logic [POS_W-1:0] b_y,
    input  logic [POS_W-1:0] b_w,
    input  logic [POS_W-1:0] b_h,
    input  logic             dir,
    output logic             overlap,
    output logic             front
);

    // One extra bit so right/bottom edges never wrap.
    logic [POS_W:0] a_r, a_b, b_r, b_b, a_xe, a_ye, b_xe, b_ye;

    assign a_xe = {1'b0, a_x};
    assign a_ye = {1'b0, a_y};
    assign b_xe = {1'b0, b_x};
    assign b_ye = {1'b0, b_y};
    assign a_r  = a_xe + {1'b0, a_w};
    assign a_b  = a_ye + {1'b0, a_h};
    assign b_r  = b_xe + {1'b0, b_w};
    assign b_b  = b_ye + {1'b0, b_h};

    assign overlap = (a_xe < b_r) && (b_xe < a_r) && (a_ye < b_b) && (b_ye < a_b);
    assign front   = dir ? (b_r <= a_r) : (b_xe >= a_xe);

endmodule

// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: one explicit state machine driving position,
// hurtbox size, facing and a one-frame strike pulse, updated once per frame.
module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int START_X     = 50,
    parameter bit START_DIR   = 1'b0,
    parameter int GROUND_Y    = 291,
    parameter int X_MIN       = 53,
    parameter int X_MAX       = 550,
    parameter int WALK_V      = 3,
    parameter int JUMP_V      = 5,
    parameter int JUMP_H      = 188,
    parameter int BODY_W      = 64,
    parameter int BODY_H      = 128,
    parameter int CROUCH_H    = 96,
    parameter int ATK_W       = 104,
    parameter int KO_W        = 128,
    parameter int ATK_FRAMES  = 12,
    parameter int ATK_ACTIVE  = 4,
    parameter int STUN_FRAMES = 8,
    parameter int KB_V        = 3
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             restart,
    input  logic [ACT_W-1:0] act,
    input  logic [POS_W-1:0] opp_x,
    input  logic [POS_W-1:0] opp_y,
    input  logic [POS_W-1:0] opp_w,
    input  logic [POS_W-1:0] opp_h,
    input  logic             opp_air,
    input  logic             opp_crouch,
    input  logic             hit_in,
    input  logic             lose,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [POS_W-1:0] size_x,
    output logic [POS_W-1:0] size_y,
    output fstate_t          state,
    output logic             dir,
    output logic             air,
    output logic             hit_out
);

    typedef logic signed [POS_W+1:0] sw_t;

    function automatic sw_t ext(input logic [POS_W-1:0] v);
        return sw_t'({2'b00, v});
    endfunction

    function automatic sw_t clamp_x(input sw_t v);
        if (v < sw_t'(X_MIN)) return sw_t'(X_MIN);
        if (v > sw_t'(X_MAX)) return sw_t'(X_MAX);
        return v;
    endfunction

    function automatic logic [POS_W-1:0] to_pos(input sw_t v);
        return v[POS_W-1:0];
    endfunction

    localparam sw_t ATK_DX = sw_t'(ATK_W - BODY_W);
    localparam sw_t APEX_Y = sw_t'(GROUND_Y - JUMP_H);

    fstate_t          state_nxt;
    logic [POS_W-1:0] pos_x_nxt, pos_y_nxt, size_x_nxt, size_y_nxt;
    logic             dir_nxt, air_nxt, hit_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             atk_prev;

    logic             atk_now, atk_edge, walk_left, walk_any;
    sw_t              step, abut_x, body_x, ny_up, ny_dn;
    logic [POS_W-1:0] cand_x, ground_x, kb_x;
    logic             blk_ov, blk_front, blocked, hit_ov, hit_front;

    assign atk_now   = act[ACT_PUNCH] | act[ACT_KICK];
    assign atk_edge  = atk_now & ~atk_prev;
    assign walk_any  = act[ACT_LEFT] ^ act[ACT_RIGHT];
    assign walk_left = act[ACT_LEFT];
    assign step      = !walk_any ? sw_t'(0) : (walk_left ? -sw_t'(WALK_V) : sw_t'(WALK_V));

    // Bounded step; in the air this is the final X, on the ground blocking applies.
    assign cand_x = to_pos(clamp_x(ext(pos_x) + step));
    assign abut_x = walk_left ? ext(opp_x) + ext(opp_w) : ext(opp_x) - sw_t'(BODY_W);

    fighter_overlap #(.POS_W(POS_W)) u_block (
        .a_x(cand_x), .a_y(POS_W'(GROUND_Y)), .a_w(POS_W'(BODY_W)), .a_h(POS_W'(BODY_H)),
        .b_x(opp_x), .b_y(opp_y), .b_w(opp_w), .b_h(opp_h),
        .dir(walk_left), .overlap(blk_ov), .front(blk_front)
    );

    // Only a step toward an overlapping grounded opponent is blocked; stepping away is free.
    assign blocked  = ~opp_air & blk_ov & blk_front & walk_any;
    assign ground_x = blocked ? to_pos(clamp_x(abut_x)) : cand_x;

    fighter_overlap #(.POS_W(POS_W)) u_hit (
        .a_x(pos_x), .a_y(pos_y), .a_w(size_x), .a_h(size_y),
        .b_x(opp_x), .b_y(opp_y), .b_w(opp_w), .b_h(opp_h),
        .dir(dir), .overlap(hit_ov), .front(hit_front)
    );

    // Body origin with any left-facing attack extension undone.
    assign body_x = (state == ATTACK && dir) ? ext(pos_x) + ATK_DX : ext(pos_x);
    assign kb_x   = to_pos(clamp_x(body_x + (dir ? sw_t'(KB_V) : -sw_t'(KB_V))));
    assign ny_up  = ext(pos_y) - sw_t'(JUMP_V);
    assign ny_dn  = ext(pos_y) + sw_t'(JUMP_V);

    always_comb begin
        // NOTE: every signal gets a default first so no path can hold a value and infer a latch.
        state_nxt  = state;
        pos_x_nxt  = pos_x;
        pos_y_nxt  = pos_y;
        size_x_nxt = size_x;
        size_y_nxt = size_y;
        dir_nxt    = dir;
        air_nxt    = air;
        hit_nxt    = 1'b0;
        cnt_nxt    = cnt;

        if (lose) begin
            state_nxt  = KO;
            pos_x_nxt  = to_pos(body_x);
            pos_y_nxt  = POS_W'(GROUND_Y);
            size_x_nxt = POS_W'(KO_W);
            size_y_nxt = POS_W'(BODY_H);
            air_nxt    = 1'b0;
            cnt_nxt    = '0;
        end else if (hit_in && state != KO) begin
            state_nxt  = STUN;
            pos_x_nxt  = kb_x;
            pos_y_nxt  = POS_W'(GROUND_Y);
            size_x_nxt = POS_W'(BODY_W);
            size_y_nxt = POS_W'(BODY_H);
            air_nxt    = 1'b0;
            cnt_nxt    = CNT_W'(STUN_FRAMES);
        end else begin
            unique case (state)
                IDLE, WALK, CROUCH: begin
                    dir_nxt    = (pos_x > opp_x);
                    pos_y_nxt  = POS_W'(GROUND_Y);
                    size_x_nxt = POS_W'(BODY_W);
                    size_y_nxt = POS_W'(BODY_H);
                    if (act[ACT_UP]) begin
                        state_nxt = AIR_UP;
                        air_nxt   = 1'b1;
                    end else if (atk_edge) begin
                        state_nxt  = ATTACK;
                        cnt_nxt    = '0;
                        size_x_nxt = POS_W'(ATK_W);
                        if (dir_nxt) pos_x_nxt = to_pos(ext(pos_x) - ATK_DX);
                    end else if (act[ACT_DOWN]) begin
                        state_nxt  = CROUCH;
                        size_y_nxt = POS_W'(CROUCH_H);
                        pos_y_nxt  = POS_W'(GROUND_Y + BODY_H - CROUCH_H);
                    end else if (walk_any) begin
                        state_nxt = WALK;
                        pos_x_nxt = ground_x;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                AIR_UP: begin
                    pos_x_nxt = cand_x;
                    if (ny_up <= APEX_Y) begin
                        pos_y_nxt = to_pos(APEX_Y);
                        state_nxt = AIR_DN;
                    end else begin
                        pos_y_nxt = to_pos(ny_up);
                    end
                end
                AIR_DN: begin
                    pos_x_nxt = cand_x;
                    if (ny_dn >= sw_t'(GROUND_Y)) begin
                        pos_y_nxt = POS_W'(GROUND_Y);
                        air_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        pos_y_nxt = to_pos(ny_dn);
                    end
                end
                ATTACK: begin
                    if (cnt == CNT_W'(ATK_FRAMES - 1)) begin
                        state_nxt  = IDLE;
                        cnt_nxt    = '0;
                        size_x_nxt = POS_W'(BODY_W);
                        pos_x_nxt  = to_pos(body_x);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        hit_nxt = (cnt_nxt == CNT_W'(ATK_ACTIVE)) && hit_ov && hit_front && !opp_crouch;
                    end
                end
                STUN: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt - 1'b1;
                        pos_x_nxt = kb_x;
                    end
                end
                KO: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Reset and restart are synchronous and identical.
    always_ff @(posedge frame_clk) begin
        // NOTE: registered state uses non-blocking assignment so all flops update from pre-edge values.
        if (Reset || restart) begin
            state    <= IDLE;
            pos_x    <= POS_W'(START_X);
            pos_y    <= POS_W'(GROUND_Y);
            size_x   <= POS_W'(BODY_W);
            size_y   <= POS_W'(BODY_H);
            dir      <= START_DIR;
            air      <= 1'b0;
            hit_out  <= 1'b0;
            cnt      <= '0;
            atk_prev <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos_x    <= pos_x_nxt;
            pos_y    <= pos_y_nxt;
            size_x   <= size_x_nxt;
            size_y   <= size_y_nxt;
            dir      <= dir_nxt;
            air      <= air_nxt;
            hit_out  <= hit_nxt;
            cnt      <= cnt_nxt;
            atk_prev <= atk_now;
        end
    end

endmodule

// File: tb/tb_fighter_ctrl.sv
// Directed self-checking bench for fighter_ctrl: walk, blocking, jump arc,
// attack pulse timing, left-facing attack offset, stun/KO/restart.
module tb_fighter_ctrl;
    import fighter_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       restart = 1'b0;
    logic [5:0] act = '0;
    logic [9:0] opp_x = 10'd400, opp_y = 10'd291, opp_w = 10'd64, opp_h = 10'd128;
    logic       opp_air = 1'b0, opp_crouch = 1'b0, hit_in = 1'b0, lose = 1'b0;
    logic [9:0] pos_x, pos_y, size_x, size_y;
    fstate_t    state;
    logic       dir, air, hit_out;

    int total = 0;
    int bad = 0;

    localparam logic [5:0] A_UP = 6'b100000, A_LEFT = 6'b001000, A_RIGHT = 6'b000100,
                           A_PUNCH = 6'b000010, A_KICK = 6'b000001;
    // {pos_x, pos_y, size_x, size_y, state, dir, air, hit_out} after reset
    localparam logic [45:0] RESET_VEC = {10'd50, 10'd291, 10'd64, 10'd128, 3'd0, 1'b0, 1'b0, 1'b0};

    fighter_ctrl dut (
        .frame_clk(frame_clk), .Reset(Reset), .restart(restart), .act(act),
        .opp_x(opp_x), .opp_y(opp_y), .opp_w(opp_w), .opp_h(opp_h),
        .opp_air(opp_air), .opp_crouch(opp_crouch), .hit_in(hit_in), .lose(lose),
        .pos_x(pos_x), .pos_y(pos_y), .size_x(size_x), .size_y(size_y),
        .state(state), .dir(dir), .air(air), .hit_out(hit_out)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        act = '0; hit_in = 0; lose = 0; opp_crouch = 0; opp_air = 0;
        opp_x = 10'd400;
        Reset = 1; tick(); Reset = 0;
    endtask

    task automatic test_reset();
        logic [45:0] got;
        do_reset();
        got = {pos_x, pos_y, size_x, size_y, state, dir, air, hit_out};
        total++;
        if (got !== RESET_VEC) begin bad++; $display("FAIL reset_vec got %h want %h", got, RESET_VEC); end
    endtask

    task automatic test_walk();
        do_reset();
        act = A_RIGHT;
        repeat (10) tick();
        total++;
        if (pos_x !== 10'd80) begin bad++; $display("FAIL walk_x got %0d want 80", pos_x); end
        total++;
        if (state !== WALK) begin bad++; $display("FAIL walk_state got %0d want %0d", state, WALK); end
        total++;
        if (dir !== 1'b0) begin bad++; $display("FAIL walk_dir got %0d want 0", dir); end
        act = '0;
    endtask

    task automatic test_block();
        int max_x = 0;
        do_reset();
        opp_x = 10'd120;
        act = A_RIGHT;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(pos_x) > max_x) max_x = int'(pos_x);
        end
        total++;
        if (max_x != 56) begin bad++; $display("FAIL block_max_x got %0d want 56", max_x); end
        act = A_LEFT;
        repeat (4) tick();
        total++;
        if (pos_x !== 10'd53) begin bad++; $display("FAIL xmin_clamp got %0d want 53", pos_x); end
        act = '0;
    endtask

    task automatic test_jump();
        int min_y = 1000;
        do_reset();
        act = A_UP;
        tick();
        act = '0;
        total++;
        if (state !== AIR_UP || air !== 1'b1) begin
            bad++; $display("FAIL jump_entry got state=%0d air=%0d want 3/1", state, air);
        end
        for (int f = 1; f <= 76; f++) begin
            tick();
            if (int'(pos_y) < min_y) min_y = int'(pos_y);
            if (f == 37) begin
                total++;
                if (pos_y !== 10'd106) begin bad++; $display("FAIL jump_f37 got %0d want 106", pos_y); end
            end
            if (f == 38) begin
                total++;
                if (pos_y !== 10'd103 || state !== AIR_DN) begin
                    bad++; $display("FAIL jump_apex got y=%0d st=%0d want 103/4", pos_y, state);
                end
            end
            if (f == 75) begin
                total++;
                if (pos_y !== 10'd288 || air !== 1'b1) begin
                    bad++; $display("FAIL jump_f75 got y=%0d air=%0d want 288/1", pos_y, air);
                end
            end
        end
        total++;
        if (pos_y !== 10'd291 || air !== 1'b0 || state !== IDLE) begin
            bad++; $display("FAIL jump_land got y=%0d air=%0d st=%0d want 291/0/0", pos_y, air, state);
        end
        total++;
        if (min_y != 103) begin bad++; $display("FAIL jump_min_y got %0d want 103", min_y); end
    endtask

    task automatic test_attack();
        int pulses;
        int pulse_f;
        do_reset();
        opp_x = 10'd120;
        act = A_RIGHT;
        repeat (3) tick();
        act = '0;
        tick();
        total++;
        if (pos_x !== 10'd56) begin bad++; $display("FAIL atk_setup_x got %0d want 56", pos_x); end
        act = A_PUNCH;
        pulses = 0; pulse_f = -1;
        for (int f = 0; f < 30; f++) begin
            tick();
            if (hit_out) begin pulses++; pulse_f = f; end
            if (f == 0) begin
                total++;
                if (state !== ATTACK || size_x !== 10'd104) begin
                    bad++; $display("FAIL atk_entry got st=%0d w=%0d want 5/104", state, size_x);
                end
            end
        end
        total++;
        if (pulses != 1 || pulse_f != 4) begin
            bad++; $display("FAIL atk_pulse got n=%0d frame=%0d want 1/4", pulses, pulse_f);
        end
        total++;
        if (state !== IDLE) begin bad++; $display("FAIL atk_held_idle got %0d want 0", state); end
        act = '0; tick(); act = A_PUNCH;
        pulses = 0;
        repeat (14) begin tick(); if (hit_out) pulses++; end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL atk_second got %0d want 1", pulses); end
        act = '0; opp_crouch = 1; tick(); act = A_PUNCH;
        pulses = 0;
        repeat (14) begin tick(); if (hit_out) pulses++; end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL atk_crouch got %0d want 0", pulses); end
        act = '0; opp_crouch = 0;
    endtask

    task automatic test_face_left();
        do_reset();
        opp_x = 10'd364;
        act = A_RIGHT;
        repeat (90) tick();
        total++;
        if (pos_x !== 10'd300) begin bad++; $display("FAIL left_setup_x got %0d want 300", pos_x); end
        act = '0; opp_x = 10'd100;
        tick();
        total++;
        if (dir !== 1'b1) begin bad++; $display("FAIL left_dir got %0d want 1", dir); end
        act = A_KICK;
        tick();
        act = '0;
        total++;
        if (pos_x !== 10'd260 || state !== ATTACK || size_x !== 10'd104) begin
            bad++; $display("FAIL left_atk got x=%0d st=%0d w=%0d want 260/5/104", pos_x, state, size_x);
        end
        repeat (11) tick();
        total++;
        if (pos_x !== 10'd260 || state !== ATTACK) begin
            bad++; $display("FAIL left_atk_f11 got x=%0d st=%0d want 260/5", pos_x, state);
        end
        tick();
        total++;
        if (pos_x !== 10'd300 || state !== IDLE || size_x !== 10'd64) begin
            bad++; $display("FAIL left_exit got x=%0d st=%0d w=%0d want 300/0/64", pos_x, state, size_x);
        end
    endtask

    task automatic test_stun_ko();
        int stun_n;
        logic [45:0] got;
        do_reset();
        hit_in = 1; tick(); hit_in = 0;
        total++;
        if (pos_x !== 10'd53 || state !== STUN) begin
            bad++; $display("FAIL stun_entry got x=%0d st=%0d want 53/6", pos_x, state);
        end
        stun_n = 1;
        repeat (10) begin tick(); if (state == STUN) stun_n++; end
        total++;
        if (stun_n != 8) begin bad++; $display("FAIL stun_len got %0d want 8", stun_n); end
        total++;
        if (state !== IDLE || pos_x !== 10'd53) begin
            bad++; $display("FAIL stun_exit got st=%0d x=%0d want 0/53", state, pos_x);
        end
        lose = 1; hit_in = 1; tick(); lose = 0; hit_in = 0;
        total++;
        if (state !== KO || size_x !== 10'd128) begin
            bad++; $display("FAIL ko_entry got st=%0d w=%0d want 7/128", state, size_x);
        end
        act = A_RIGHT; hit_in = 1;
        repeat (3) tick();
        act = '0; hit_in = 0;
        total++;
        if (state !== KO || pos_x !== 10'd53) begin
            bad++; $display("FAIL ko_absorb got st=%0d x=%0d want 7/53", state, pos_x);
        end
        restart = 1; tick(); restart = 0;
        got = {pos_x, pos_y, size_x, size_y, state, dir, air, hit_out};
        total++;
        if (got !== RESET_VEC) begin bad++; $display("FAIL restart_vec got %h want %h", got, RESET_VEC); end
    endtask

    task automatic test_back_to_back();
        logic [45:0] got;
        do_reset();
        opp_x = 10'd100;
        act = A_PUNCH;
        repeat (4) tick();
        total++;
        if (state !== ATTACK) begin bad++; $display("FAIL b2b_attack got %0d want 5", state); end
        restart = 1; act = '0; tick(); restart = 0;
        got = {pos_x, pos_y, size_x, size_y, state, dir, air, hit_out};
        total++;
        if (got !== RESET_VEC) begin bad++; $display("FAIL b2b_restart got %h want %h", got, RESET_VEC); end
        repeat (6) tick();
        total++;
        if (state !== IDLE || hit_out !== 1'b0) begin
            bad++; $display("FAIL b2b_after got st=%0d hit=%0d want 0/0", state, hit_out);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_block();
        test_jump();
        test_attack();
        test_face_left();
        test_stun_ko();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
